rca_tmr_voter: RTL

Downstream checking stage for the fault-tolerant ripple-carry adder. It takes the sum and carry-out of three redundant RCA replicas (A, B, C) and produces a registered, bitwise majority-voted result. It flags and attributes disagreements, keeps saturating error counts per replica, and retires a replica that disagrees persistently, then degrades to duplex comparison.

---
 rtl/rca_ft_pkg.sv | 18 +
 rtl/rca_tmr_voter_if.sv | 32 +++
 rtl/rca_tmr_voter_monitor.sv | 82 ++++++++
 rtl/rca_tmr_voter.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/rca_ft_pkg.sv
// Shared types and constants for the fault-tolerant RCA checking stage.
//   health_e      : per-replica health state
//   ID_*          : faulty_id encoding (0 = none, 1 = A, 2 = B, 3 = C)
//   consec_w()    : width of the consecutive-disagreement counter
package rca_ft_pkg;

  typedef enum logic [1:0] {HEALTHY, SUSPECT, DEAD} health_e;

  localparam logic [1:0] ID_NONE = 2'd0;
  localparam logic [1:0] ID_A    = 2'd1;
  localparam logic [1:0] ID_B    = 2'd2;
  localparam logic [1:0] ID_C    = 2'd3;

  function automatic int unsigned consec_w(input int unsigned thresh);
    return $clog2(thresh + 1);
  endfunction

endpackage

// File: rtl/rca_tmr_voter_if.sv
// Bus between the three RCA replicas and the TMR voter.
//   master : drives replica words, in_valid and clr_errs; observes voted results
//   slave  : the voter side
interface rca_tmr_voter_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] sum_a, sum_b, sum_c;
  logic             cout_a, cout_b, cout_c;
  logic             clr_errs;
  logic             out_valid;
  logic [WIDTH-1:0] sum_out;
  logic             cout_out;
  logic             mismatch;
  logic             uncorrectable;
  logic [1:0]       faulty_id;
  logic [2:0]       replica_dead;
  logic [CNT_W-1:0] err_cnt_a, err_cnt_b, err_cnt_c;

  modport master (
    output in_valid, sum_a, sum_b, sum_c, cout_a, cout_b, cout_c, clr_errs,
    input  out_valid, sum_out, cout_out, mismatch, uncorrectable, faulty_id,
           replica_dead, err_cnt_a, err_cnt_b, err_cnt_c
  );

  modport slave (
    input  in_valid, sum_a, sum_b, sum_c, cout_a, cout_b, cout_c, clr_errs,
    output out_valid, sum_out, cout_out, mismatch, uncorrectable, faulty_id,
           replica_dead, err_cnt_a, err_cnt_b, err_cnt_c
  );
endinterface

// File: rtl/rca_tmr_voter_monitor.sv
// Per-replica health tracker: health FSM, consecutive-disagreement counter and
// saturating error counter.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_txn          : a transaction is being judged for this replica
//   i_disagree     : this replica disagreed (already qualified by the voter)
//   i_freeze       : hold all state
//   i_clr          : clear health and counters (wins over i_txn)
//   o_dead         : replica retired
//   o_err_cnt      : saturating disagreement count
module tmr_replica_monitor
  import rca_ft_pkg::*;
#(
  parameter int unsigned FAULT_THRESH = 4,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_txn,
  input  logic             i_disagree,
  input  logic             i_freeze,
  input  logic             i_clr,
  output logic             o_dead,
  output logic [CNT_W-1:0] o_err_cnt
);
  localparam int unsigned CW = consec_w(FAULT_THRESH);
  localparam logic [CW-1:0] THRESH = CW'(FAULT_THRESH);

  health_e          r_state, w_state_d;
  logic [CW-1:0]    r_consec, w_consec_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

  always_comb begin
    w_state_d  = r_state;
    w_consec_d = r_consec;
    w_cnt_d    = r_cnt;
    if (i_clr) begin
      w_state_d  = HEALTHY;
      w_consec_d = '0;
      w_cnt_d    = '0;
    end else if (i_txn && !i_freeze) begin
      case (r_state)
        HEALTHY: begin
          if (i_disagree) begin
            w_state_d  = SUSPECT;
            w_consec_d = CW'(1);
            w_cnt_d    = w_cnt_inc;
          end
        end
        SUSPECT: begin
          if (i_disagree) begin
            w_consec_d = r_consec + 1'b1;
            w_cnt_d    = w_cnt_inc;
            if (r_consec + 1'b1 == THRESH) w_state_d = DEAD;
          end else begin
            w_state_d  = HEALTHY;
            w_consec_d = '0;
          end
        end
        default: ;  // DEAD is sticky
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= HEALTHY;
      r_consec <= '0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_d;
      r_consec <= w_consec_d;
      r_cnt    <= w_cnt_d;
    end
  end

  assign o_dead    = (r_state == DEAD);
  assign o_err_cnt = r_cnt;

endmodule

// File: rtl/rca_tmr_voter.sv
// TMR checking stage for three ripple-carry adder replicas. Registers a bitwise
// majority-voted {cout, sum}, flags and attributes disagreements, tracks
// replica health, and degrades to duplex comparison once a replica retires.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   bus            : replica inputs, clr_errs, voted outputs, health/counters
module rca_tmr_voter
  import rca_ft_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned FAULT_THRESH = 4,
  parameter int unsigned CNT_W        = 8
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  rca_tmr_voter_if.slave bus
);
  localparam int unsigned WW = WIDTH + 1;

  logic [WW-1:0] w_a, w_b, w_c, w_vote, w_word, w_lo, w_hi;
  logic [2:0]    w_raw_dis, w_dis, w_dead;
  logic [1:0]    w_n_dead, w_n_dis, w_fid;
  logic          w_mis, w_unc, w_txn, w_freeze;

  logic [WW-1:0] r_word;
  logic          r_valid, r_mis, r_unc;
  logic [1:0]    r_fid;

  assign w_a    = {bus.cout_a, bus.sum_a};
  assign w_b    = {bus.cout_b, bus.sum_b};
  assign w_c    = {bus.cout_c, bus.sum_c};
  assign w_vote = (w_a & w_b) | (w_a & w_c) | (w_b & w_c);

  assign w_raw_dis = {w_c != w_vote, w_b != w_vote, w_a != w_vote};
  assign w_n_dis   = 2'(w_raw_dis[0]) + 2'(w_raw_dis[1]) + 2'(w_raw_dis[2]);
  assign w_n_dead  = 2'(w_dead[0]) + 2'(w_dead[1]) + 2'(w_dead[2]);

  // Live pair in duplex mode; lo is the lower-indexed live replica.
  always_comb begin
    w_lo = w_a;
    w_hi = w_b;
    if (w_dead[0]) begin
      w_lo = w_b;
      w_hi = w_c;
    end else if (w_dead[1]) begin
      w_hi = w_c;
    end
  end

  always_comb begin
    w_word   = w_vote;
    w_mis    = 1'b0;
    w_unc    = 1'b0;
    w_fid    = ID_NONE;
    w_dis    = 3'b000;
    w_txn    = bus.in_valid;
    w_freeze = 1'b0;
    case (w_n_dead)
      2'd0: begin
        w_dis = w_raw_dis;
        if (w_n_dis == 2'd1) begin
          w_mis = 1'b1;
          w_fid = w_raw_dis[0] ? ID_A : (w_raw_dis[1] ? ID_B : ID_C);
        end else if (w_n_dis != 2'd0) begin
          w_unc = 1'b1;
        end
      end
      2'd1: begin
        w_word = w_lo;
        // A split pair can't be attributed, so it must not move either FSM.
        if (w_lo != w_hi) begin
          w_unc = 1'b1;
          w_txn = 1'b0;
        end
      end
      default: begin
        w_freeze = 1'b1;
        if (!w_dead[0])      w_word = w_a;
        else if (!w_dead[1]) w_word = w_b;
        else if (!w_dead[2]) w_word = w_c;
        else                 w_word = w_a;
      end
    endcase
  end

  tmr_replica_monitor #(.FAULT_THRESH(FAULT_THRESH), .CNT_W(CNT_W)) u_mon_a (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_txn      (w_txn),
    .i_disagree (w_dis[0]),
    .i_freeze   (w_freeze),
    .i_clr      (bus.clr_errs),
    .o_dead     (w_dead[0]),
    .o_err_cnt  (bus.err_cnt_a)
  );

  tmr_replica_monitor #(.FAULT_THRESH(FAULT_THRESH), .CNT_W(CNT_W)) u_mon_b (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_txn      (w_txn),
    .i_disagree (w_dis[1]),
    .i_freeze   (w_freeze),
    .i_clr      (bus.clr_errs),
    .o_dead     (w_dead[1]),
    .o_err_cnt  (bus.err_cnt_b)
  );

  tmr_replica_monitor #(.FAULT_THRESH(FAULT_THRESH), .CNT_W(CNT_W)) u_mon_c (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_txn      (w_txn),
    .i_disagree (w_dis[2]),
    .i_freeze   (w_freeze),
    .i_clr      (bus.clr_errs),
    .o_dead     (w_dead[2]),
    .o_err_cnt  (bus.err_cnt_c)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_word  <= '0;
      r_mis   <= 1'b0;
      r_unc   <= 1'b0;
      r_fid   <= ID_NONE;
    end else begin
      r_valid <= bus.in_valid;
      r_word  <= bus.in_valid ? w_word : '0;
      r_mis   <= bus.in_valid & w_mis;
      r_unc   <= bus.in_valid & w_unc;
      r_fid   <= bus.in_valid ? w_fid : ID_NONE;
    end
  end

  assign bus.out_valid     = r_valid;
  assign bus.sum_out       = r_word[WIDTH-1:0];
  assign bus.cout_out      = r_word[WIDTH];
  assign bus.mismatch      = r_mis;
  assign bus.uncorrectable = r_unc;
  assign bus.faulty_id     = r_fid;
  assign bus.replica_dead  = w_dead;

endmodule
